vga_pattern_gen: RTL and testbench
==================================

# vga_pattern_gen

Pixel-source stage directly downstream of the 720p sync generator. Consumes its sync, data-enable and pixel-address outputs and produces a 24-bit RGB stream with syncs re-aligned to the pixel data, ready for the HDMI encoder. Four test patterns are supported, including an animated bouncing box. Pattern selection is frame-synchronous, so no frame is ever torn.

## Interface
- H_ACTIVE, 1280: active pixels per line.
- V_ACTIVE, 720: active lines per frame.
- BOX_SIZE, 64: moving-box edge length in pixels.
- BOX_STEP, 2: box displacement per frame, pixels per axis.
- clk  input  1  pixel clock, 74.25 MHz; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- hsync_in  input  1  active-low horizontal sync from the sync generator.
- vsync_in  input  1  active-low vertical sync from the sync generator.
- de_in  input  1  active-video flag; the sync generator's `ready` output.
- col_in  input  11  pixel column; valid only while de_in=1.
- row_in  input  11  pixel row; valid only while de_in=1.
- mode_req  input  2  requested pattern: 0 colour bars, 1 checkerboard, 2 gradient, 3 moving box. Asynchronous to frames; quasi-static.
- hsync_out  output  1  hsync_in delayed by 2 cycles.
- vsync_out  output  1  vsync_in delayed by 2 cycles.
- de_out  output  1  de_in delayed by 2 cycles.
- rgb_out  output  24  pixel colour as {R[7:0],G[7:0],B[7:0]}.
- mode_cur  output  2  pattern currently in effect.
- frame_cnt  output  8  frame counter; +1 per frame start; wraps 255 to 0.

## Operation
- Frame start (fs): a registered falling edge of vsync_in, i.e. the previous sample is 1 and the current sample is 0. fs is a one-cycle internal pulse.
- On fs:
  - mode_cur loads mode_req.
  - frame_cnt increments.
  - The box position updates.
- A change on mode_req at any other time has no effect until the next fs.
- Colour bars (mode 0): bar = col_in/160, clamped to 7. Colours in order: white, yellow, cyan, green, magenta, red, blue, black, each channel 8'hFF or 8'h00.
- Checkerboard (mode 1): col_in[5]^row_in[5] = 1 gives 24'hFFFFFF; otherwise 24'h000000.
- Gradient (mode 2): R = col_in[10:3], G = row_in[9:2], B = R^G.
- Moving box (mode 3): pixels with box_x <= col_in < box_x+BOX_SIZE and box_y <= row_in < box_y+BOX_SIZE are 24'hFFFFFF. All other pixels are 24'h000040.
- Box motion:
  - Each axis has a position and a direction bit, both updated on every fs regardless of mode.
  - Moving positive: if x >= H_ACTIVE-BOX_SIZE-BOX_STEP, x = H_ACTIVE-BOX_SIZE and direction flips. Otherwise x += BOX_STEP.
  - Moving negative: if x <= BOX_STEP, x = 0 and direction flips. Otherwise x -= BOX_STEP.
  - The y axis is identical, using V_ACTIVE.
  - All comparisons are unsigned 11-bit; position never leaves [0, ACTIVE-BOX_SIZE].
- Blanking: rgb_out = 0 whenever de_out = 0, regardless of mode.
- Addresses are used exactly as received; a column or row >= ACTIVE produces no error (bars clamp; other patterns use the bits directly).

## Timing
- Pipeline depth is 2 for every output path.
  - Stage 1 registers the inputs and computes the bar index, checker bit, gradient bytes and box-hit flag.
  - Stage 2 muxes by mode_cur and gates with de.
- hsync_out, vsync_out, de_out and rgb_out for a given input sample appear together 2 cycles later.
- mode_cur is sampled in stage 1. A mode change at fs therefore affects pixels from the first active line of the new frame, never mid-frame.
- Reset values:
  - hsync_out = 1, vsync_out = 1 (inactive).
  - de_out = 0, rgb_out = 0, mode_cur = 0, frame_cnt = 0.
  - box_x = 0, box_y = 0, both directions positive.
  - Internal vsync edge register = 1, so no spurious fs after reset.
- Reset mid-frame: outputs return to reset values immediately. The first fs after release is the next genuine vsync falling edge.
- If vsync_in is held low for many cycles, only one fs is generated.

## Structure
- Shared package vga_pkg:
  - Mode encodings MODE_BARS, MODE_CHECK, MODE_GRAD, MODE_BOX.
  - 8-entry colour-bar constant table.
  - Box background colour 24'h000040.
- Sub-module vga_box_motion: position/direction registers and the bounce logic for one axis, parameterised by ACTIVE, SIZE and STEP. It is instantiated twice (x with H_ACTIVE, y with V_ACTIVE) and advances on fs.

## Test plan
- Reset check: assert rst_n=0 mid-line. All outputs take their reset values asynchronously; after release, the first fs occurs only at the next vsync_in falling edge.
- Latency: toggle hsync_in, vsync_in and de_in at known cycles. The outputs match the inputs delayed by exactly 2 cycles; rgb_out = 0 whenever de_out = 0.
- Colour bars: mode 0, row 100. Column 0 gives 24'hFFFFFF, 160 gives 24'hFFFF00, 1279 gives 24'h000000, and out-of-range column 1280 clamps to black.
- Frame-synchronous mode change: switch mode_req 0→1 mid-frame. Pixels stay colour bars until the next fs. At the next frame, (col 32, row 0) = 24'hFFFFFF and (col 32, row 32) = 24'h000000. frame_cnt increments by exactly 1.
- Box bounce: run 610 frames. box_x follows 0, 2, …, 1216 (reached at frame 608), then 1214. box_y reaches 656 at frame 328, then decreases. Spot-check that the pixel at (box_x, box_y) is 24'hFFFFFF and the pixel at (box_x+64, box_y) is 24'h000040.
- Counter wrap: run 256 frames from reset; frame_cnt returns to 0.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared geometry, pattern modes, colour tables and pipeline stage types
package vga_pkg;
    localparam int H_ACTIVE = 1280;
    localparam int V_ACTIVE = 720;
    localparam int BOX_SIZE = 64;
    localparam int BOX_STEP = 2;
    typedef enum logic [1:0] {MODE_BARS, MODE_CHECK, MODE_GRAD, MODE_BOX} mode_e;
    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [23:0] BAR_RGB [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };
    localparam logic [23:0] BOX_BG = 24'h000040;
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        mode_e      mode;
        logic [2:0] bar;
        logic       chk;
        logic [7:0] r;
        logic [7:0] g;
        logic       hit;
    } s1_t;
    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
    } s2_t;
endpackage

// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if: timing stream from the sync generator and re-aligned RGB stream to the encoder
//   *_in  : hsync/vsync (active-low), de, col/row pixel address
//   *_out : hsync/vsync/de delayed, rgb {R,G,B}
//   master = sync-generator/encoder side, slave = pattern generator
interface vga_pattern_gen_if;
    logic        hsync_in;
    logic        vsync_in;
    logic        de_in;
    logic [10:0] col_in;
    logic [10:0] row_in;
    logic        hsync_out;
    logic        vsync_out;
    logic        de_out;
    logic [23:0] rgb_out;
    modport master (output hsync_in, vsync_in, de_in, col_in, row_in,
                    input  hsync_out, vsync_out, de_out, rgb_out);
    modport slave  (input  hsync_in, vsync_in, de_in, col_in, row_in,
                    output hsync_out, vsync_out, de_out, rgb_out);
endinterface

// File: rtl/vga_box_motion.sv
// vga_box_motion: one axis of the bouncing box, position in [0, ACTIVE-SIZE]
//   clk, rst_n : pixel clock, async active-low reset
//   adv        : frame-start pulse, advances the position by STEP
//   pos        : current box edge position
module vga_box_motion import vga_pkg::*; #(
    parameter int ACTIVE = H_ACTIVE,
    parameter int SIZE   = BOX_SIZE,
    parameter int STEP   = BOX_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    output logic [10:0] pos
);
    localparam logic [10:0] HI   = 11'(ACTIVE - SIZE);
    localparam logic [10:0] TURN = 11'(ACTIVE - SIZE - STEP);
    localparam logic [10:0] ST   = 11'(STEP);
    logic [10:0] pos_q, pos_d;
    logic        dir_q, dir_d;
    // dir_q = 1 means moving towards zero
    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (adv && !dir_q) begin
            pos_d = (pos_q >= TURN) ? HI : pos_q + ST;
            dir_d = (pos_q >= TURN);
        end else if (adv) begin
            pos_d = (pos_q <= ST) ? 11'd0 : pos_q - ST;
            dir_d = (pos_q > ST);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0;
            dir_q <= 1'b0;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end
    assign pos = pos_q;
endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: 2-stage test-pattern source with frame-synchronous mode select
//   clk, rst_n : pixel clock, async active-low reset
//   vid        : timing in / delayed timing + rgb out
//   mode_req   : requested pattern, taken only at frame start
//   mode_cur   : pattern in effect
//   frame_cnt  : frame-start counter, wraps at 256
module vga_pattern_gen import vga_pkg::*; (
    input  logic              clk,
    input  logic              rst_n,
    vga_pattern_gen_if.slave  vid,
    input  logic [1:0]        mode_req,
    output logic [1:0]        mode_cur,
    output logic [7:0]        frame_cnt
);
    localparam s1_t S1_RST = '{hs: 1'b1, vs: 1'b1, de: 1'b0, mode: MODE_BARS, bar: 3'd0,
                               chk: 1'b0, r: 8'd0, g: 8'd0, hit: 1'b0};
    localparam s2_t S2_RST = '{hs: 1'b1, vs: 1'b1, de: 1'b0, rgb: 24'd0};
    s1_t         s1_q, s1_d;
    s2_t         s2_q, s2_d;
    mode_e       mode_q, mode_d;
    logic [7:0]  frame_q, frame_d;
    logic        fs;
    logic [10:0] box_x, box_y, bar_div;
    logic [11:0] c12, r12, bx12, by12;
    logic [23:0] pix;
    // stage-1 vsync doubles as the edge register; reset to 1 blocks a spurious fs
    assign fs = s1_q.vs & ~vid.vsync_in;
    vga_box_motion #(.ACTIVE(H_ACTIVE), .SIZE(BOX_SIZE), .STEP(BOX_STEP)) u_box_x (
        .clk(clk), .rst_n(rst_n), .adv(fs), .pos(box_x));
    vga_box_motion #(.ACTIVE(V_ACTIVE), .SIZE(BOX_SIZE), .STEP(BOX_STEP)) u_box_y (
        .clk(clk), .rst_n(rst_n), .adv(fs), .pos(box_y));
    always_comb begin
        mode_d  = fs ? mode_e'(mode_req) : mode_q;
        frame_d = fs ? frame_q + 8'd1 : frame_q;
        bar_div = vid.col_in / 11'd160;
        c12     = {1'b0, vid.col_in};
        r12     = {1'b0, vid.row_in};
        bx12    = {1'b0, box_x};
        by12    = {1'b0, box_y};
        s1_d    = '{hs: vid.hsync_in, vs: vid.vsync_in, de: vid.de_in, mode: mode_q,
                    bar: (bar_div > 11'd7) ? 3'd7 : bar_div[2:0],
                    chk: vid.col_in[5] ^ vid.row_in[5],
                    r: vid.col_in[10:3], g: vid.row_in[9:2],
                    hit: (c12 >= bx12) && (c12 < bx12 + 12'(BOX_SIZE)) &&
                         (r12 >= by12) && (r12 < by12 + 12'(BOX_SIZE))};
        pix     = (s1_q.mode == MODE_BARS)  ? BAR_RGB[s1_q.bar] :
                  (s1_q.mode == MODE_CHECK) ? {24{s1_q.chk}} :
                  (s1_q.mode == MODE_GRAD)  ? {s1_q.r, s1_q.g, s1_q.r ^ s1_q.g} :
                  s1_q.hit ? 24'hFFFFFF : BOX_BG;
        s2_d    = '{hs: s1_q.hs, vs: s1_q.vs, de: s1_q.de, rgb: s1_q.de ? pix : 24'd0};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= S1_RST;
            s2_q    <= S2_RST;
            mode_q  <= MODE_BARS;
            frame_q <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            mode_q  <= mode_d;
            frame_q <= frame_d;
        end
    end
    assign vid.hsync_out = s2_q.hs;
    assign vid.vsync_out = s2_q.vs;
    assign vid.de_out    = s2_q.de;
    assign vid.rgb_out   = s2_q.rgb;
    assign mode_cur      = mode_q;
    assign frame_cnt     = frame_q;
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: directed checks of latency, patterns, mode switching, reset and box bounce
module tb_vga_pattern_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] mode_req = 2'd0;
    logic [1:0] mode_cur;
    logic [7:0] frame_cnt;
    int         checks = 0;
    int         errors = 0;
    logic [2:0] vec [10];
    localparam logic [31:0] WHITE = 32'hFFFFFF;
    localparam logic [31:0] BG    = 32'h000040;

    vga_pattern_gen_if vif();
    vga_pattern_gen dut (.clk(clk), .rst_n(rst_n), .vid(vif), .mode_req(mode_req),
                         .mode_cur(mode_cur), .frame_cnt(frame_cnt));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        vif.hsync_in = 1'b1;
        vif.vsync_in = 1'b1;
        vif.de_in    = 1'b0;
        vif.col_in   = '0;
        vif.row_in   = '0;
    endtask

    task automatic pix(input int c, input int r, input logic [31:0] exp, input string tag);
        @(negedge clk);
        vif.de_in  = 1'b1;
        vif.col_in = 11'(c);
        vif.row_in = 11'(r);
        @(negedge clk);
        vif.de_in  = 1'b0;
        @(negedge clk);
        chk({tag, " de"}, 32'(vif.de_out), 32'd1);
        chk(tag, 32'(vif.rgb_out), exp);
    endtask

    task automatic frame();
        @(negedge clk);
        vif.vsync_in = 1'b0;
        @(negedge clk);
        vif.vsync_in = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " hs"},    32'(vif.hsync_out), 32'd1);
        chk({tag, " vs"},    32'(vif.vsync_out), 32'd1);
        chk({tag, " de"},    32'(vif.de_out),    32'd0);
        chk({tag, " rgb"},   32'(vif.rgb_out),   32'd0);
        chk({tag, " mode"},  32'(mode_cur),      32'd0);
        chk({tag, " frame"}, 32'(frame_cnt),     32'd0);
    endtask

    initial begin
        // {hsync, vsync, de}
        vec = '{3'b110, 3'b010, 3'b010, 3'b111, 3'b111, 3'b100, 3'b101, 3'b110, 3'b011, 3'b110};
        idle();
        #1 rst_n = 1'b0;
        #20 chk_reset_vals("reset");
        @(negedge clk) rst_n = 1'b1;

        // latency: col 0 row 100 in bars mode is white whenever de is set
        vif.row_in = 11'd100;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk("lat hs", 32'(vif.hsync_out), 32'(vec[i-2][2]));
                chk("lat vs", 32'(vif.vsync_out), 32'(vec[i-2][1]));
                chk("lat de", 32'(vif.de_out),    32'(vec[i-2][0]));
                chk("lat rgb", 32'(vif.rgb_out),  vec[i-2][0] ? WHITE : 32'd0);
            end
            if (i < 10) {vif.hsync_in, vif.vsync_in, vif.de_in} = vec[i];
            else idle();
        end
        chk("lat frame", 32'(frame_cnt), 32'd1);

        // colour bars
        pix(0, 100, 32'hFFFFFF, "bar c0");
        pix(160, 100, 32'hFFFF00, "bar c160");
        pix(480, 100, 32'h00FF00, "bar c480");
        pix(800, 100, 32'hFF0000, "bar c800");
        pix(1279, 100, 32'h000000, "bar c1279");
        pix(1280, 100, 32'h000000, "bar c1280 clamp");

        // mode change mid-frame waits for the next frame start
        pix(32, 0, WHITE, "bars c32r0");
        mode_req = 2'd1;
        pix(32, 32, WHITE, "pre-fs bars c32r32");
        chk("pre-fs mode", 32'(mode_cur), 32'd0);
        frame();
        chk("post-fs mode", 32'(mode_cur), 32'd1);
        chk("post-fs frame", 32'(frame_cnt), 32'd2);
        pix(32, 0, WHITE, "chk c32r0");
        pix(32, 32, 32'd0, "chk c32r32");
        pix(0, 0, 32'd0, "chk c0r0");

        // gradient: R=125, G=75, B=R^G
        mode_req = 2'd2;
        frame();
        chk("grad frame", 32'(frame_cnt), 32'd3);
        pix(1000, 300, 32'h7D4B36, "grad c1000r300");

        // reset mid-line
        @(negedge clk);
        vif.de_in  = 1'b1;
        vif.col_in = 11'd1000;
        vif.row_in = 11'd300;
        repeat (3) @(negedge clk);
        chk("pre-rst rgb", 32'(vif.rgb_out), 32'h7D4B36);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midline reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        repeat (5) @(negedge clk);
        chk("no fs after release", 32'(frame_cnt), 32'd0);
        vif.vsync_in = 1'b0;
        repeat (20) @(negedge clk);
        chk("held vsync one fs", 32'(frame_cnt), 32'd1);
        chk("held vsync mode", 32'(mode_cur), 32'd2);
        vif.vsync_in = 1'b1;
        repeat (2) @(negedge clk);

        // box bounce and frame counter wrap from a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mode_req = 2'd3;
        for (int f = 1; f <= 610; f++) begin
            frame();
            if (f == 1) begin
                chk("f1 frame", 32'(frame_cnt), 32'd1);
                pix(2, 2, WHITE, "f1 box corner");
                pix(66, 2, BG, "f1 right of box");
                pix(1, 2, BG, "f1 left of box");
                pix(2, 65, WHITE, "f1 bottom row");
                pix(2, 66, BG, "f1 below box");
            end
            if (f == 255) chk("f255 frame", 32'(frame_cnt), 32'd255);
            if (f == 256) chk("f256 wrap", 32'(frame_cnt), 32'd0);
            if (f == 328) begin
                pix(656, 656, WHITE, "f328 corner");
                pix(655, 656, BG, "f328 left");
                pix(656, 655, BG, "f328 above");
                pix(720, 656, BG, "f328 right");
                pix(656, 719, WHITE, "f328 bottom edge");
            end
            if (f == 608) begin
                pix(1216, 96, WHITE, "f608 corner");
                pix(1279, 96, WHITE, "f608 right edge");
                pix(1280, 96, BG, "f608 x+64");
                pix(1215, 96, BG, "f608 left");
                pix(1216, 95, BG, "f608 above");
            end
            if (f == 609) begin
                pix(1214, 94, WHITE, "f609 corner");
                pix(1213, 94, BG, "f609 left");
                pix(1278, 94, BG, "f609 x+64");
            end
            if (f == 610) begin
                pix(1212, 92, WHITE, "f610 corner");
                pix(1276, 92, BG, "f610 x+64");
                pix(1212, 91, BG, "f610 above");
                chk("f610 frame", 32'(frame_cnt), 32'd98);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
